ws2812_rx: RTL and testbench

Receiver/decoder for the single-wire WS2812 NRZ LED stream. It samples a led_data-style line and measures each high pulse to classify the bit as 0 or 1. Bits are assembled MSB-first into 24-bit pixel words, and the frame ends on the latch (reset) gap. Used for loopback checking of the LED transmit path, and for capturing the DOUT of a strip daisy chain.

---
 rtl/ws2812_pkg.sv | 14 +
 rtl/ws2812_rx_sync.sv | 20 ++
 rtl/ws2812_rx.sv | 123 ++++++++++++
 tb/tb_ws2812_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 timing constants for a 50 MHz clock and receiver state encoding.
package ws2812_pkg;
    localparam int T0H_CYC   = 20;
    localparam int T1H_CYC   = 40;
    localparam int BIT_CYC   = 62;
    localparam int RESET_CYC = 2500;
    localparam int MAX_LEDS  = 64;

    typedef enum logic [1:0] {S_SYNC, S_LOW, S_HIGH} rx_state_t;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (&v) ? v : v + 12'd1;
    endfunction
endpackage

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: 2-FF synchronizer for the serial line with rise/fall strobes.
module ws2812_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sh_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sh_q <= '0;
        else         sh_q <= {sh_q[1:0], d_i};
    end

    assign q_o    = sh_q[1];
    assign rise_o = sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ line decoder; classifies high pulses into bits, assembles
// MSB-first 24-bit pixel words and closes frames on the latch gap.
module ws2812_rx #(
    parameter int BIT_THRESH   = (ws2812_pkg::T0H_CYC + ws2812_pkg::T1H_CYC) / 2,
    parameter int MIN_HIGH     = 5,
    parameter int MAX_HIGH     = 75,
    parameter int RESET_CYCLES = ws2812_pkg::RESET_CYC,
    parameter int MAX_LEDS     = ws2812_pkg::MAX_LEDS
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        led_data_in,
    output logic [23:0] pix_data,
    output logic [5:0]  pix_num,
    output logic        pix_valid,
    output logic        frame_done,
    output logic [6:0]  frame_len,
    output logic        err
);
    import ws2812_pkg::*;

    localparam logic [11:0] THRESH_C = 12'(BIT_THRESH);
    localparam logic [11:0] MIN_C    = 12'(MIN_HIGH);
    localparam logic [11:0] MAX_C    = 12'(MAX_HIGH);
    localparam logic [11:0] GAP_C    = 12'(RESET_CYCLES);
    localparam logic [6:0]  LEDS_C   = 7'(MAX_LEDS);

    rx_state_t   state_q;
    logic [11:0] hcnt_q, lcnt_q, hcnt_d, lcnt_d;
    logic [4:0]  bit_cnt_q;
    logic [6:0]  pix_cnt_q;
    logic [22:0] sr_q;
    logic [23:0] word_d;
    logic        line, rise, fall, bit_d, abort, gap_hit;

    ws2812_rx_sync u_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (led_data_in),
        .q_o    (line),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign hcnt_d  = sat_inc12(hcnt_q);
    assign lcnt_d  = sat_inc12(lcnt_q);
    assign bit_d   = hcnt_q >= THRESH_C;
    assign word_d  = {sr_q, bit_d};
    // Fires only on the cycle the low count steps onto the gap length.
    assign gap_hit = !line && lcnt_d == GAP_C && lcnt_q != GAP_C;
    assign abort   = state_q == S_HIGH && (fall ? hcnt_q < MIN_C : hcnt_d > MAX_C);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_SYNC;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            bit_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            sr_q       <= '0;
            pix_data   <= '0;
            pix_num    <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            err        <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            if (abort) begin
                err       <= 1'b1;
                state_q   <= S_SYNC;
                lcnt_q    <= '0;
                bit_cnt_q <= '0;
                pix_cnt_q <= '0;
            end else begin
                case (state_q)
                    S_SYNC: begin
                        lcnt_q <= line ? '0 : lcnt_d;
                        if (gap_hit) state_q <= S_LOW;
                    end
                    S_LOW: begin
                        if (rise) begin
                            state_q <= S_HIGH;
                            hcnt_q  <= 12'd1;
                        end else begin
                            lcnt_q <= lcnt_d;
                            if (gap_hit) begin
                                err        <= bit_cnt_q != '0;
                                frame_done <= pix_cnt_q != '0;
                                if (pix_cnt_q != '0) frame_len <= pix_cnt_q;
                                bit_cnt_q  <= '0;
                                pix_cnt_q  <= '0;
                            end
                        end
                    end
                    S_HIGH: begin
                        if (fall) begin
                            state_q   <= S_LOW;
                            lcnt_q    <= '0;
                            sr_q      <= word_d[22:0];
                            bit_cnt_q <= (bit_cnt_q == 5'd23) ? '0 : bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd23) begin
                                if (pix_cnt_q == LEDS_C) begin
                                    err <= 1'b1;
                                end else begin
                                    pix_valid <= 1'b1;
                                    pix_data  <= word_d;
                                    pix_num   <= pix_cnt_q[5:0];
                                    pix_cnt_q <= pix_cnt_q + 7'd1;
                                end
                            end
                        end else begin
                            hcnt_q <= hcnt_d;
                        end
                    end
                    default: state_q <= S_SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed vector bench for the WS2812 receiver with hand-computed
// expectations plus sequences for threshold, glitch, overflow and reset corners.
module tb_ws2812_rx;
    import ws2812_pkg::*;

    localparam int GAP = 2520;

    logic        clk = 1'b0, rst_n = 1'b0, led = 1'b0;
    logic [23:0] pix_data;
    logic [5:0]  pix_num;
    logic        pix_valid, frame_done, err;
    logic [6:0]  frame_len;

    int tests = 0, fails = 0;
    int n_done = 0, n_err = 0, n_both = 0;
    logic [23:0] pv_d[$];
    logic [5:0]  pv_n[$];

    typedef struct {
        int               nw;
        logic [2:0][23:0] w;
        int               tail;
        int               exp_pix;
        int               exp_done;
        int               exp_len;
        int               exp_err;
        int               exp_both;
    } vec_t;
    vec_t tv[5];

    ws2812_rx dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .led_data_in (led),
        .pix_data    (pix_data),
        .pix_num     (pix_num),
        .pix_valid   (pix_valid),
        .frame_done  (frame_done),
        .frame_len   (frame_len),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_valid) begin
            pv_d.push_back(pix_data);
            pv_n.push_back(pix_num);
        end
        if (frame_done) n_done++;
        if (err) n_err++;
        if (err && frame_done) n_both++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int h, input int l);
        led = 1'b1;
        repeat (h) @(negedge clk);
        led = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic fast);
        if (fast) pulse(b ? 31 : 6, 4);
        else      pulse(b ? T1H_CYC : T0H_CYC, BIT_CYC - (b ? T1H_CYC : T0H_CYC));
    endtask

    task automatic send_word(input logic [23:0] w, input logic fast);
        for (int i = 23; i >= 0; i--) send_bit(w[i], fast);
    endtask

    task automatic gap();
        led = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    initial begin
        int p0, d0, e0, b0, lat, first;
        logic [23:0] wv;
        tv[0] = '{nw: 1, w: {24'h0, 24'h0, 24'hFF0000}, tail: 0,
                  exp_pix: 1, exp_done: 1, exp_len: 1, exp_err: 0, exp_both: 0};
        tv[1] = '{nw: 3, w: {24'h000001, 24'hABCDEF, 24'h123456}, tail: 0,
                  exp_pix: 3, exp_done: 1, exp_len: 3, exp_err: 0, exp_both: 0};
        tv[2] = '{nw: 0, w: {24'h0, 24'h0, 24'h0}, tail: 12,
                  exp_pix: 0, exp_done: 0, exp_len: 3, exp_err: 1, exp_both: 0};
        tv[3] = '{nw: 2, w: {24'h0, 24'h55AA55, 24'hC0FFEE}, tail: 12,
                  exp_pix: 2, exp_done: 1, exp_len: 2, exp_err: 1, exp_both: 1};
        tv[4] = '{nw: 1, w: {24'h0, 24'h0, 24'h800001}, tail: 0,
                  exp_pix: 1, exp_done: 1, exp_len: 1, exp_err: 0, exp_both: 0};

        repeat (5) @(negedge clk);
        check("reset_pix_data", pix_data, 0);
        check("reset_ctrl", {pix_num, pix_valid, frame_done, frame_len, err}, 0);
        rst_n = 1'b1;
        gap();

        for (int v = 0; v < 5; v++) begin
            p0 = pv_d.size(); d0 = n_done; e0 = n_err; b0 = n_both;
            for (int i = 0; i < tv[v].nw; i++) send_word(tv[v].w[i], 1'b0);
            for (int i = 0; i < tv[v].tail; i++) send_bit(i[0], 1'b0);
            gap();
            check($sformatf("v%0d_pix_count", v), pv_d.size() - p0, tv[v].exp_pix);
            for (int i = 0; i < tv[v].exp_pix && p0 + i < pv_d.size(); i++) begin
                check($sformatf("v%0d_data%0d", v, i), pv_d[p0+i], tv[v].w[i]);
                check($sformatf("v%0d_num%0d", v, i), pv_n[p0+i], i);
            end
            check($sformatf("v%0d_done", v), n_done - d0, tv[v].exp_done);
            check($sformatf("v%0d_len", v), frame_len, tv[v].exp_len);
            check($sformatf("v%0d_err", v), n_err - e0, tv[v].exp_err);
            check($sformatf("v%0d_both", v), n_both - b0, tv[v].exp_both);
        end

        // Pulse-length boundaries on the low bits: 75->1, 5->0, 29->0, 30->1.
        p0 = pv_d.size(); d0 = n_done; e0 = n_err;
        wv = 24'hABCDE8;
        for (int i = 23; i >= 4; i--) send_bit(wv[i], 1'b0);
        pulse(75, 20);
        pulse(5, 40);
        pulse(29, 40);
        led = 1'b1;
        repeat (30) @(negedge clk);
        led = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (pix_valid) lat = i;
        end
        check("thr_valid_latency", lat, 3);
        gap();
        check("thr_pix_count", pv_d.size() - p0, 1);
        if (pv_d.size() > p0) check("thr_data", pv_d[p0], 24'hABCDE9);
        check("thr_done", n_done - d0, 1);
        check("thr_len", frame_len, 1);
        check("thr_err", n_err - e0, 0);

        // Short glitch mid-word disarms the receiver until a full gap.
        p0 = pv_d.size(); d0 = n_done; e0 = n_err;
        wv = 24'h3C5A96;
        for (int i = 23; i >= 14; i--) send_bit(wv[i], 1'b1);
        pulse(4, 10);
        check("glitch_err", n_err - e0, 1);
        send_word(24'h123456, 1'b1);
        gap();
        check("glitch_ignored_pix", pv_d.size() - p0, 0);
        check("glitch_no_done", n_done - d0, 0);
        send_word(24'h00FF00, 1'b1);
        gap();
        check("glitch_resume_pix", pv_d.size() - p0, 1);
        if (pv_d.size() > p0) begin
            check("glitch_resume_data", pv_d[p0], 24'h00FF00);
            check("glitch_resume_num", pv_n[p0], 0);
        end
        check("glitch_resume_done", n_done - d0, 1);
        check("glitch_total_err", n_err - e0, 1);

        // Over-long high: error on the 76th synchronized high cycle.
        p0 = pv_d.size(); d0 = n_done; e0 = n_err;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        led = 1'b1;
        first = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (err && first == 0) first = i;
        end
        led = 1'b0;
        check("long_high_err_cycle", first, 78);
        gap();
        check("long_high_err_count", n_err - e0, 1);
        check("long_high_no_done", n_done - d0, 0);
        check("long_high_no_pix", pv_d.size() - p0, 0);

        // 65 words: the 65th overflows the pixel index.
        p0 = pv_d.size(); d0 = n_done; e0 = n_err;
        for (int i = 0; i < 65; i++) send_word(24'(i), 1'b1);
        gap();
        check("ovf_pix_count", pv_d.size() - p0, 64);
        for (int j = 0; j < 64 && p0 + j < pv_d.size(); j++) begin
            check($sformatf("ovf_data%0d", j), pv_d[p0+j], j);
            check($sformatf("ovf_num%0d", j), pv_n[p0+j], j);
        end
        check("ovf_err", n_err - e0, 1);
        check("ovf_done", n_done - d0, 1);
        check("ovf_len", frame_len, 64);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        p0 = pv_d.size(); d0 = n_done; e0 = n_err;
        wv = 24'hF0F0F0;
        for (int i = 23; i >= 14; i--) send_bit(wv[i], 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_pix_data", pix_data, 0);
        check("arst_pix_num", pix_num, 0);
        check("arst_frame_len", frame_len, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_word(24'hAAAAAA, 1'b1);
        send_word(24'h555555, 1'b1);
        gap();
        check("arst_unarmed_pix", pv_d.size() - p0, 0);
        check("arst_unarmed_done", n_done - d0, 0);
        send_word(24'h0F0F0F, 1'b0);
        gap();
        check("arst_resume_pix", pv_d.size() - p0, 1);
        if (pv_d.size() > p0) begin
            check("arst_resume_data", pv_d[p0], 24'h0F0F0F);
            check("arst_resume_num", pv_n[p0], 0);
        end
        check("arst_resume_done", n_done - d0, 1);
        check("arst_resume_len", frame_len, 1);
        check("arst_err", n_err - e0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
